// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, frame layout constants and helpers for the segment scan controller
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DWELL,
        SAMPLE
    } state_e;

    localparam int FRAME_BITS = 8;
    localparam int N_FRAMES   = 16;
    localparam int COL_MSB    = 7;
    localparam int SCR_MSB    = 5;
    localparam int DIG_MSB    = 3;

    // Frame byte {col, scr, digit}; scr is fc[1:0], col is fc[3:2].
    function automatic logic [FRAME_BITS-1:0] frame_byte(input logic [3:0] fc, input logic [15:0] digits);
        logic [FRAME_BITS-1:0] b;
        b = '0;
        b[COL_MSB -: 2] = fc[3:2];
        b[SCR_MSB -: 2] = fc[1:0];
        b[DIG_MSB -: 4] = digits[{fc[1:0], 2'b00} +: 4];
        return b;
    endfunction

    // Key map position 4*scr+col for a given frame counter.
    function automatic logic [3:0] key_idx(input logic [3:0] fc);
        return {fc[1:0], fc[3:2]};
    endfunction

endpackage

// File: rtl/seg_frame_tx.sv
// seg_frame_tx: 8-bit parallel-to-serial frame shifter with enable framing.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : load byte_i and begin a frame on this edge
//   byte_i      : frame byte, sent MSB first
//   en_o        : registered frame enable, high for FRAME_BITS cycles
//   mosi_o      : registered serial data, 0 whenever en_o is low
//   done_o      : high during the last enabled bit cycle
module seg_frame_tx
    import seg_scan_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [FRAME_BITS-1:0] byte_i,
    output logic                  en_o,
    output logic                  mosi_o,
    output logic                  done_o
);

    localparam int CW = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] sh_q;
    logic [CW-1:0]         cnt_q;
    logic                  en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else if (start_i) begin
            sh_q  <= byte_i;
            cnt_q <= '0;
            en_q  <= 1'b1;
        end else if (en_q) begin
            // Clearing the shifter on the last bit keeps mosi low through the dwell.
            sh_q  <= done_o ? '0 : {sh_q[FRAME_BITS-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            en_q  <= !done_o;
        end
    end

    assign en_o   = en_q;
    assign mosi_o = sh_q[FRAME_BITS-1];
    assign done_o = en_q && (cnt_q == CW'(FRAME_BITS-1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans 16 display/key frames per sweep and builds a sweep-debounced key map.
//   clk, rst      : clock, synchronous active-high reset
//   scan_en       : 1 = run continuous sweeps (examined at frame end)
//   digits_i      : digit for screen s in bits [4s+3:4s]
//   miso_i        : key return from the decoder, low = selected key pressed
//   en_o, mosi_o  : serial frame interface to the decoder
//   key_state_o   : key map updated once per completed sweep
//   key_evt_o     : one-cycle pulse when key_state_o changes
//   sweep_done_o  : one-cycle pulse after each completed sweep
//   busy_o        : high whenever not idle
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DWELL_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [15:0] digits_i,
    input  logic        miso_i,
    output logic        en_o,
    output logic        mosi_o,
    output logic [15:0] key_state_o,
    output logic        key_evt_o,
    output logic        sweep_done_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic [3:0]  fc_q, fc_d;
    logic [9:0]  dc_q, dc_d;
    logic [15:0] shadow_q, shadow_d, shadow_smp;
    logic [15:0] key_q, key_d;
    logic        evt_q, evt_d, done_q, done_d;
    logic        tx_start, tx_done;

    always_comb begin
        state_d    = state_q;
        fc_d       = fc_q;
        dc_d       = dc_q;
        shadow_d   = shadow_q;
        key_d      = key_q;
        evt_d      = 1'b0;
        done_d     = 1'b0;
        shadow_smp = shadow_q;
        shadow_smp[key_idx(fc_q)] = ~miso_i;
        case (state_q)
            IDLE: begin
                fc_d     = '0;
                shadow_d = '0;
                if (scan_en) state_d = SHIFT;
            end
            SHIFT: begin
                dc_d = '0;
                if (tx_done) state_d = DWELL;
            end
            DWELL: begin
                dc_d = dc_q + 1'b1;
                // DWELL covers all en-low cycles except the final SAMPLE cycle.
                if (dc_q == 10'(DWELL_CYC - 2)) state_d = SAMPLE;
            end
            SAMPLE: begin
                fc_d     = fc_q + 1'b1;
                shadow_d = shadow_smp;
                // The sweep completes on the last frame even if scanning stops here.
                if (fc_q == 4'(N_FRAMES - 1)) begin
                    key_d    = shadow_smp;
                    done_d   = 1'b1;
                    evt_d    = shadow_smp != key_q;
                    shadow_d = '0;
                end
                if (scan_en) begin
                    state_d = SHIFT;
                end else begin
                    state_d  = IDLE;
                    fc_d     = '0;
                    shadow_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A frame is loaded on every edge that enters SHIFT, including back-to-back frames.
    assign tx_start = (state_d == SHIFT) && (state_q != SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fc_q     <= '0;
            dc_q     <= '0;
            shadow_q <= '0;
            key_q    <= '0;
            evt_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fc_q     <= fc_d;
            dc_q     <= dc_d;
            shadow_q <= shadow_d;
            key_q    <= key_d;
            evt_q    <= evt_d;
            done_q   <= done_d;
        end
    end

    seg_frame_tx u_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (tx_start),
        .byte_i  (frame_byte(fc_d, digits_i)),
        .en_o    (en_o),
        .mosi_o  (mosi_o),
        .done_o  (tx_done)
    );

    assign key_state_o  = key_q;
    assign key_evt_o    = evt_q;
    assign sweep_done_o = done_q;
    assign busy_o       = state_q != IDLE;

endmodule
